// File: rtl/net_bus_mux_n.sv
// rtl/net_bus_mux_n.sv - N-port NetBus mux: DEST-steered write path, priority/round-robin read merge.
// Optional macro NETBUS_MUX_RR_STARVE_EN bounds how long real-time ports can starve round-robin ports.
module net_bus_mux_n #(
    parameter int DATA_WIDTH = 4,
    parameter int PORTS = 7,
    parameter logic [PORTS-1:0] REAL_TIME_MASK = '0,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int W = DATA_WIDTH * 9 + 14
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [W-1:0]              WDATA,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [W-1:0]              RDATA,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [PORTS*W-1:0]        M_WDATA,
    output logic [PORTS-1:0]          M_WVALID,
    input  logic [PORTS-1:0]          M_WREADY,
    input  logic [PORTS*W-1:0]        M_RDATA,
    input  logic [PORTS-1:0]          M_RVALID,
    output logic [PORTS-1:0]          M_RREADY,
    output logic [DROP_CNT_WIDTH-1:0] DROP_CNT
);

    typedef enum logic [1:0] {T_IDLE, T_FWD, T_DROP} tx_state_t;
    typedef enum logic {R_IDLE, R_LOCK} rx_state_t;

    tx_state_t                 tx_state, tx_next;
    logic [W-1:0]              wreg;
    logic                      wreg_valid;
    logic [3:0]                sel;
    logic [PORTS-1:0]          sel_oh;
    logic                      sel_ready, w_acc, w_last, dest_ok, w_load, drop_start;
    logic [3:0]                w_dest;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    always_comb begin
        sel_oh = '0;
        for (int k = 0; k < PORTS; k++) sel_oh[k] = (sel == 4'(k));
    end

    assign w_dest     = WDATA[W-1:W-4];
    assign w_last     = WDATA[W-5];
    assign dest_ok    = ({1'b0, w_dest} < 5'(PORTS));
    assign sel_ready  = |(sel_oh & M_WREADY);
    assign WREADY     = (tx_state == T_DROP) | ~wreg_valid | sel_ready;
    assign w_acc      = WVALID & WREADY;
    assign w_load     = w_acc & (((tx_state == T_IDLE) & dest_ok) | (tx_state == T_FWD));
    assign drop_start = w_acc & (tx_state == T_IDLE) & ~dest_ok;

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:        if (w_acc && !w_last) tx_next = dest_ok ? T_FWD : T_DROP;
            T_FWD, T_DROP: if (w_acc && w_last) tx_next = T_IDLE;
            default:       tx_next = T_IDLE;
        endcase
    end

    // sel moves only when a new frame's first word loads, so the old word drains first
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tx_state   <= T_IDLE;
            wreg       <= '0;
            wreg_valid <= 1'b0;
            sel        <= '0;
            drop_cnt   <= '0;
        end else begin
            tx_state <= tx_next;
            if (w_load) begin
                wreg       <= WDATA;
                wreg_valid <= 1'b1;
            end else if (sel_ready) begin
                wreg_valid <= 1'b0;
            end
            if (w_load && tx_state == T_IDLE) sel <= w_dest;
            if (drop_start && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign M_WDATA  = {PORTS{wreg}};
    assign M_WVALID = sel_oh & {PORTS{wreg_valid}};
    assign DROP_CNT = drop_cnt;

    rx_state_t        rx_state, rx_next;
    logic [3:0]       gnt, rr_ptr, rt_gnt, rr_gnt, arb_gnt;
    logic [PORTS-1:0] gnt_oh, rt_req, nrt_req;
    logic             rt_found, rr_found, arb_valid, arb_is_rt, starve_force;
    logic             mr_ready, r_acc, r_last, gnt_is_rt;
    logic [W-1:0]     r_word, rreg;
    logic             rreg_valid;

    assign rt_req  = M_RVALID & REAL_TIME_MASK;
    assign nrt_req = M_RVALID & ~REAL_TIME_MASK;

    always_comb begin
        rt_found = 1'b0;
        rt_gnt   = '0;
        rr_found = 1'b0;
        rr_gnt   = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (rt_req[k]) begin
                rt_found = 1'b1;
                rt_gnt   = 4'(k);
            end
        end
        for (int i = 1; i <= PORTS; i++) begin
            if (!rr_found && ((nrt_req >> ((int'(rr_ptr) + i) % PORTS)) & PORTS'(1)) != '0) begin
                rr_found = 1'b1;
                rr_gnt   = 4'((int'(rr_ptr) + i) % PORTS);
            end
        end
    end

`ifdef NETBUS_MUX_RR_STARVE_EN
    logic [3:0] starve_cnt;

    // after 8 real-time wins over waiting round-robin ports, one round-robin pick is forced
    assign starve_force = (starve_cnt >= 4'd8) & rr_found;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            starve_cnt <= '0;
        else if (rx_state == R_IDLE && arb_valid)
            starve_cnt <= (arb_is_rt && |nrt_req) ? starve_cnt + 4'd1 : 4'd0;
    end
`else
    assign starve_force = 1'b0;
`endif

    assign arb_valid = rt_found | rr_found;
    assign arb_is_rt = rt_found & ~starve_force;
    assign arb_gnt   = arb_is_rt ? rt_gnt : rr_gnt;

    always_comb begin
        gnt_oh = '0;
        r_word = '0;
        for (int k = 0; k < PORTS; k++) begin
            gnt_oh[k] = (gnt == 4'(k));
            if (gnt == 4'(k)) r_word = M_RDATA[k*W +: W];
        end
    end

    assign gnt_is_rt = |(gnt_oh & REAL_TIME_MASK);
    assign mr_ready  = (rx_state == R_LOCK) & (~rreg_valid | RREADY);
    assign M_RREADY  = gnt_oh & {PORTS{mr_ready}};
    assign r_acc     = |(M_RREADY & M_RVALID);
    assign r_last    = r_word[W-5];

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (arb_valid) rx_next = R_LOCK;
            R_LOCK:  if (r_acc && r_last) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_state   <= R_IDLE;
            gnt        <= '0;
            rr_ptr     <= 4'(PORTS - 1);
            rreg       <= '0;
            rreg_valid <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == R_IDLE && arb_valid) gnt <= arb_gnt;
            if (r_acc) begin
                rreg       <= r_word;
                rreg_valid <= 1'b1;
            end else if (RREADY) begin
                rreg_valid <= 1'b0;
            end
            if (r_acc && r_last && !gnt_is_rt) rr_ptr <= gnt;
        end
    end

    assign RDATA  = rreg;
    assign RVALID = rreg_valid;

endmodule

// File: tb/tb_net_bus_mux_n.sv
// tb/tb_net_bus_mux_n.sv - directed self-checking bench for net_bus_mux_n.
module tb_net_bus_mux_n;
    localparam int DW = 4;
    localparam int P = 7;
    localparam int W = DW * 9 + 14;
    localparam int DCW = 16;

    logic           CLK = 1'b0;
    logic           RESETn = 1'b0;
    logic [W-1:0]   WDATA = '0;
    logic           WVALID = 1'b0;
    logic           WREADY;
    logic [W-1:0]   RDATA;
    logic           RVALID;
    logic           RREADY = 1'b0;
    logic [P*W-1:0] M_WDATA;
    logic [P-1:0]   M_WVALID;
    logic [P-1:0]   M_WREADY = '1;
    logic [P*W-1:0] M_RDATA = '0;
    logic [P-1:0]   M_RVALID = '0;
    logic [P-1:0]   M_RREADY;
    logic [DCW-1:0] DROP_CNT;

    net_bus_mux_n #(
        .DATA_WIDTH(DW), .PORTS(P), .REAL_TIME_MASK(7'b0000100), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .CLK(CLK), .RESETn(RESETn),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
        .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
        .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;

    function automatic logic [W-1:0] mk(input logic [3:0] dest, input logic last, input logic [15:0] pay);
        return {dest, last, {(W-21){1'b0}}, pay};
    endfunction

    // per-port read sources: words queued in rmem, presented in order
    logic [W-1:0] rmem [P][32];
    int           rhead [P] = '{default: 0};
    int           rtail [P] = '{default: 0};
    logic [P-1:0] src_hs;

    always @(posedge CLK) begin
        src_hs = M_RVALID & M_RREADY;
        #1;
        for (int k = 0; k < P; k++) begin
            if (src_hs[k]) rhead[k] = rhead[k] + 1;
            if (rhead[k] < rtail[k]) begin
                M_RVALID[k] = 1'b1;
                M_RDATA[k*W +: W] = rmem[k][rhead[k]];
            end else begin
                M_RVALID[k] = 1'b0;
            end
        end
    end

    logic [W-1:0] rx_got [128];
    int           rx_cyc [128];
    int           rx_n = 0;
    int           cyc = 0;
    logic [W-1:0] tx_got [128];
    int           tx_port [128];
    int           tx_n = 0;

    always @(posedge CLK) begin
        cyc = cyc + 1;
        if (RVALID === 1'b1 && RREADY === 1'b1 && rx_n < 128) begin
            rx_got[rx_n] = RDATA;
            rx_cyc[rx_n] = cyc;
            rx_n = rx_n + 1;
        end
        for (int k = 0; k < P; k++) begin
            if (M_WVALID[k] === 1'b1 && M_WREADY[k] === 1'b1 && tx_n < 128) begin
                tx_got[tx_n] = M_WDATA[k*W +: W];
                tx_port[tx_n] = k;
                tx_n = tx_n + 1;
            end
        end
    end

    task automatic load_src(input int port, input logic [W-1:0] word);
        rmem[port][rtail[port]] = word;
        rtail[port] = rtail[port] + 1;
    endtask

    task automatic wait_rx(input int target);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge CLK);
            if (rx_n >= target) done = 1;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rx_timeout: got %0d words want %0d", rx_n, target); end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL reset_wready: got %b want 1", WREADY); end
        n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", RVALID); end
        n_checks++; if (M_WVALID !== 7'b0) begin n_fail++; $display("FAIL reset_m_wvalid: got %b want 0", M_WVALID); end
        n_checks++; if (M_RREADY !== 7'b0) begin n_fail++; $display("FAIL reset_m_rready: got %b want 0", M_RREADY); end
        n_checks++; if (DROP_CNT !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", DROP_CNT); end
        RESETn = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_tx_basic();
        logic [W-1:0] w [3];
        w[0] = mk(4'd2, 1'b0, 16'h0101);
        w[1] = mk(4'd5, 1'b0, 16'h0102);
        w[2] = mk(4'd9, 1'b1, 16'h0103);
        M_WREADY = '1;
        for (int i = 0; i < 3; i++) begin
            WDATA = w[i]; WVALID = 1'b1;
            @(negedge CLK);
            n_checks++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL tx_basic_wready%0d: got %b want 1", i, WREADY); end
            if (i > 0) begin
                n_checks++; if (M_WVALID !== 7'b0000100) begin n_fail++; $display("FAIL tx_basic_wvalid%0d: got %b want 0000100", i, M_WVALID); end
                n_checks++; if (M_WDATA[2*W +: W] !== w[i-1]) begin n_fail++; $display("FAIL tx_basic_data%0d: got %h want %h", i, M_WDATA[2*W +: W], w[i-1]); end
            end else begin
                n_checks++; if (M_WVALID !== 7'b0) begin n_fail++; $display("FAIL tx_basic_idle: got %b want 0", M_WVALID); end
            end
            @(posedge CLK); #1;
        end
        WVALID = 1'b0;
        @(negedge CLK);
        n_checks++; if (M_WVALID !== 7'b0000100) begin n_fail++; $display("FAIL tx_basic_wvalid3: got %b want 0000100", M_WVALID); end
        n_checks++; if (M_WDATA[2*W +: W] !== w[2]) begin n_fail++; $display("FAIL tx_basic_data3: got %h want %h", M_WDATA[2*W +: W], w[2]); end
        @(posedge CLK); #1;
        @(negedge CLK);
        n_checks++; if (M_WVALID !== 7'b0) begin n_fail++; $display("FAIL tx_basic_drain: got %b want 0", M_WVALID); end
        @(posedge CLK); #1;
    endtask

    task automatic test_tx_drop();
        logic [W-1:0] w [2];
        n_checks++; if (DROP_CNT !== 16'd0) begin n_fail++; $display("FAIL drop_cnt_before: got %0d want 0", DROP_CNT); end
        for (int i = 0; i < 4; i++) begin
            WDATA = mk(4'd9, i == 3, 16'(16'h0200 + i)); WVALID = 1'b1;
            @(negedge CLK);
            n_checks++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL drop_wready%0d: got %b want 1", i, WREADY); end
            n_checks++; if (M_WVALID !== 7'b0) begin n_fail++; $display("FAIL drop_wvalid%0d: got %b want 0", i, M_WVALID); end
            @(posedge CLK); #1;
        end
        WVALID = 1'b0;
        @(negedge CLK);
        n_checks++; if (M_WVALID !== 7'b0) begin n_fail++; $display("FAIL drop_wvalid_after: got %b want 0", M_WVALID); end
        n_checks++; if (DROP_CNT !== 16'd1) begin n_fail++; $display("FAIL drop_cnt_after: got %0d want 1", DROP_CNT); end
        @(posedge CLK); #1;
        w[0] = mk(4'd0, 1'b0, 16'h0211);
        w[1] = mk(4'd0, 1'b1, 16'h0212);
        for (int i = 0; i < 2; i++) begin
            WDATA = w[i]; WVALID = 1'b1;
            @(negedge CLK);
            if (i > 0) begin
                n_checks++; if (M_WVALID !== 7'b0000001) begin n_fail++; $display("FAIL post_drop_wvalid: got %b want 0000001", M_WVALID); end
                n_checks++; if (M_WDATA[0 +: W] !== w[0]) begin n_fail++; $display("FAIL post_drop_data0: got %h want %h", M_WDATA[0 +: W], w[0]); end
            end
            @(posedge CLK); #1;
        end
        WVALID = 1'b0;
        @(negedge CLK);
        n_checks++; if (M_WDATA[0 +: W] !== w[1] || M_WVALID !== 7'b0000001) begin n_fail++; $display("FAIL post_drop_data1: got %h/%b want %h/0000001", M_WDATA[0 +: W], M_WVALID, w[1]); end
        @(posedge CLK); #1;
    endtask

    task automatic test_tx_backpressure();
        logic [W-1:0] w [4];
        int base;
        base = tx_n;
        for (int i = 0; i < 4; i++) w[i] = mk(4'd2, i == 3, 16'(16'h0301 + i));
        M_WREADY = '1;
        WDATA = w[0]; WVALID = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        M_WREADY = 7'b1111011;
        WDATA = w[1];
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_checks++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL bp_wready%0d: got %b want 0", i, WREADY); end
            n_checks++; if (M_WDATA[2*W +: W] !== w[0] || M_WVALID !== 7'b0000100) begin n_fail++; $display("FAIL bp_hold%0d: got %h/%b want %h/0000100", i, M_WDATA[2*W +: W], M_WVALID, w[0]); end
            @(posedge CLK); #1;
        end
        M_WREADY = '1;
        @(negedge CLK);
        n_checks++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b want 1", WREADY); end
        @(posedge CLK); #1;
        WDATA = w[2];
        @(negedge CLK); @(posedge CLK); #1;
        WDATA = w[3];
        @(negedge CLK); @(posedge CLK); #1;
        WVALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (tx_n - base !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", tx_n - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (tx_got[base+i] !== w[i] || tx_port[base+i] !== 2) begin n_fail++; $display("FAIL bp_word%0d: got %h@%0d want %h@2", i, tx_got[base+i], tx_port[base+i], w[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w [3];
        logic [P-1:0] ev [3];
        int           pt [3];
        w[0] = mk(4'd1, 1'b1, 16'h0401); ev[0] = 7'b0000010; pt[0] = 1;
        w[1] = mk(4'd6, 1'b0, 16'h0402); ev[1] = 7'b1000000; pt[1] = 6;
        w[2] = mk(4'd6, 1'b1, 16'h0403); ev[2] = 7'b1000000; pt[2] = 6;
        M_WREADY = '1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin WDATA = w[i]; WVALID = 1'b1; end else WVALID = 1'b0;
            @(negedge CLK);
            if (i < 3) begin
                n_checks++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL b2b_wready%0d: got %b want 1", i, WREADY); end
            end
            if (i > 0) begin
                n_checks++; if (M_WVALID !== ev[i-1] || M_WDATA[pt[i-1]*W +: W] !== w[i-1]) begin n_fail++; $display("FAIL b2b_out%0d: got %b/%h want %b/%h", i - 1, M_WVALID, M_WDATA[pt[i-1]*W +: W], ev[i-1], w[i-1]); end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_rx_round_robin();
        logic [W-1:0] e [6];
        int base;
        base = rx_n;
        RREADY = 1'b1;
        e[0] = mk(4'd1, 1'b0, 16'h0011); e[1] = mk(4'd1, 1'b1, 16'h0012);
        e[2] = mk(4'd3, 1'b0, 16'h0031); e[3] = mk(4'd3, 1'b1, 16'h0032);
        e[4] = mk(4'd5, 1'b0, 16'h0051); e[5] = mk(4'd5, 1'b1, 16'h0052);
        load_src(5, e[4]); load_src(5, e[5]);
        load_src(3, e[2]); load_src(3, e[3]);
        load_src(1, e[0]); load_src(1, e[1]);
        wait_rx(base + 6);
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (rx_got[base+i] !== e[i]) begin n_fail++; $display("FAIL rr_word%0d: got %h want %h", i, rx_got[base+i], e[i]); end
        end
        n_checks++; if (rx_cyc[base+1] - rx_cyc[base] !== 1) begin n_fail++; $display("FAIL rr_in_frame_gap: got %0d want 1", rx_cyc[base+1] - rx_cyc[base]); end
        n_checks++; if (rx_cyc[base+2] - rx_cyc[base+1] !== 2) begin n_fail++; $display("FAIL rr_frame_gap: got %0d want 2", rx_cyc[base+2] - rx_cyc[base+1]); end
    endtask

    task automatic test_rx_real_time();
        logic [W-1:0] e [4];
        int base;
        base = rx_n;
        e[0] = mk(4'd2, 1'b0, 16'h0021); e[1] = mk(4'd2, 1'b1, 16'h0022);
        e[2] = mk(4'd0, 1'b0, 16'h0001); e[3] = mk(4'd0, 1'b1, 16'h0002);
        load_src(0, e[2]); load_src(0, e[3]);
        load_src(2, e[0]); load_src(2, e[1]);
        wait_rx(base + 4);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rx_got[base+i] !== e[i]) begin n_fail++; $display("FAIL rt_word%0d: got %h want %h", i, rx_got[base+i], e[i]); end
        end
    endtask

    task automatic test_rx_starve();
        logic [W-1:0] e [10];
        int base;
        base = rx_n;
`ifdef NETBUS_MUX_RR_STARVE_EN
        for (int i = 0; i < 8; i++) e[i] = mk(4'd2, 1'b1, 16'(16'h02a0 + i));
        e[8] = mk(4'd0, 1'b1, 16'h000f);
        e[9] = mk(4'd2, 1'b1, 16'h02a8);
`else
        for (int i = 0; i < 9; i++) e[i] = mk(4'd2, 1'b1, 16'(16'h02a0 + i));
        e[9] = mk(4'd0, 1'b1, 16'h000f);
`endif
        for (int i = 0; i < 9; i++) load_src(2, mk(4'd2, 1'b1, 16'(16'h02a0 + i)));
        load_src(0, mk(4'd0, 1'b1, 16'h000f));
        wait_rx(base + 10);
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (rx_got[base+i] !== e[i]) begin n_fail++; $display("FAIL starve_word%0d: got %h want %h", i, rx_got[base+i], e[i]); end
        end
    endtask

    task automatic test_reset_mid();
        RREADY = 1'b0;
        M_WREADY = '0;
        load_src(4, mk(4'd4, 1'b0, 16'h0041));
        load_src(4, mk(4'd4, 1'b0, 16'h0042));
        load_src(4, mk(4'd4, 1'b1, 16'h0043));
        WDATA = mk(4'd3, 1'b0, 16'h0501); WVALID = 1'b1;
        @(negedge CLK); @(posedge CLK); #1;
        WDATA = mk(4'd3, 1'b0, 16'h0502);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        n_checks++; if (M_WVALID !== 7'b0001000 || RVALID !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b/%b want 0001000/1", M_WVALID, RVALID); end
        n_checks++; if (DROP_CNT !== 16'd1) begin n_fail++; $display("FAIL mid_pre_drop: got %0d want 1", DROP_CNT); end
        #2;
        RESETn = 1'b0;
        #1;
        n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid: got %b want 0", RVALID); end
        n_checks++; if (M_WVALID !== 7'b0) begin n_fail++; $display("FAIL mid_m_wvalid: got %b want 0", M_WVALID); end
        n_checks++; if (M_RREADY !== 7'b0) begin n_fail++; $display("FAIL mid_m_rready: got %b want 0", M_RREADY); end
        WVALID = 1'b0;
        rtail[4] = rhead[4];
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        M_WREADY = '1;
        @(negedge CLK);
        n_checks++; if (WREADY !== 1'b1) begin n_fail++; $display("FAIL mid_post_wready: got %b want 1", WREADY); end
        n_checks++; if (DROP_CNT !== 16'd0) begin n_fail++; $display("FAIL mid_post_drop: got %0d want 0", DROP_CNT); end
        n_checks++; if (RVALID !== 1'b0 || M_WVALID !== 7'b0) begin n_fail++; $display("FAIL mid_post_idle: got %b/%b want 0/0", RVALID, M_WVALID); end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_drop();
        test_tx_backpressure();
        test_back_to_back();
        test_rx_round_robin();
        test_rx_real_time();
        test_rx_starve();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/net_bus_mux_n.md
Name: net_bus_mux_n

Overview:
Parametrised N-port NetBus multiplexer for a single clock domain. Write path: steers frames from one upstream write channel to one of PORTS downstream channels, selected by a destination field in the first word. Read path: merges PORTS upstream read channels into one read channel, with strict-priority real-time ports and round-robin for the rest. Grants are frame-locked. Sits between a NetBus endpoint and up to 16 NetBus peers on the same clock, with no CDC FIFOs.

Parameters:
DATA_WIDTH, 4, payload unit; bus word width W = DATA_WIDTH*9+14
PORTS, 7, number of downstream ports, 2..16
REAL_TIME_MASK, 0, PORTS-bit mask; bit k=1 makes port k a strict-priority read port
DROP_CNT_WIDTH, 16, width of the dropped-frame counter

Ports:
CLK  in  1  single clock, rising edge
RESETn  in  1  asynchronous active-low reset
WDATA  in  W  upstream write word
WVALID  in  1  upstream write valid
WREADY  out  1  upstream write ready
RDATA  out  W  merged read word
RVALID  out  1  merged read valid
RREADY  in  1  merged read ready
M_WDATA  out  PORTS*W  per-port write data; port k at [k*W +: W]
M_WVALID  out  PORTS  per-port write valid
M_WREADY  in  PORTS  per-port write ready
M_RDATA  in  PORTS*W  per-port read data; port k at [k*W +: W]
M_RVALID  in  PORTS  per-port read valid
M_RREADY  out  PORTS  per-port read ready
DROP_CNT  out  DROP_CNT_WIDTH  count of frames dropped for bad destination

Behaviour:
- Word fields: DEST = word[W-1:W-4]; LAST = word[W-5]. Words are never modified.
- Transfer occurs when VALID and READY are both high on a rising CLK edge.
- Once asserted, VALID and DATA hold until accepted, on every output.
- Reset (async assert, sync release) values:
  - all M_WVALID = 0, RVALID = 0, DROP_CNT = 0
  - TX FSM = T_IDLE, RX FSM = R_IDLE
  - round-robin pointer = PORTS-1
  - WREADY = 1 after reset; all M_RREADY = 0.
- TX register slice: one shared output register, data and valid.
  - M_WDATA for all ports = register data.
  - M_WVALID[k] = reg_valid & (sel == k).
  - Latency WDATA to M_WDATA: 1 cycle.
- TX FSM:
  - T_IDLE: on accepted word with DEST < PORTS, latch sel = DEST and load the register. If !LAST go to T_FWD; a single-word frame stays in T_IDLE. On DEST >= PORTS, drop the word; go to T_DROP if !LAST, else stay.
  - T_FWD: WREADY = !reg_valid | M_WREADY[sel]. Forward each word. When the LAST word is accepted, go to T_IDLE. sel does not change mid-frame, whatever DEST bits later words carry.
  - T_DROP: WREADY = 1; discard words until LAST, then go to T_IDLE.
  - In T_IDLE, WREADY = !reg_valid | M_WREADY[sel]. This gives full throughput back-to-back, including a frame to a new port while the previous frame's last word drains: sel updates only when the register is loaded.
- DROP_CNT increments once per dropped frame, on acceptance of its first word. It saturates at all-ones.
- RX FSM:
  - R_IDLE: if any M_RVALID is set, choose grant g and go to R_LOCK next cycle. Grant arbitration costs 1 idle cycle per frame.
  - Grant selection: lowest-index port with M_RVALID & REAL_TIME_MASK; if none, the first valid non-real-time port after the round-robin pointer, wrapping modulo PORTS.
  - R_LOCK: M_RREADY[g] = !RVALID | RREADY; all other M_RREADY are 0. Accepted words load the RDATA/RVALID register; latency 1 cycle.
  - On acceptance of a word with LAST: return to R_IDLE. If g is not real-time, pointer = g.
- Simultaneous real-time and round-robin requests: real-time wins. The pointer does not move on a real-time grant.
- If M_RVALID[g] drops mid-frame, the lock holds; there is no timeout.
- Reset mid-frame: all state is cleared, and any partial frame in the register is discarded.

Optional Feature:
NETBUS_MUX_RR_STARVE_EN.
- With the macro: a 4-bit counter tracks consecutive real-time grants while any non-real-time port is requesting. When it reaches 8, the next arbitration ignores REAL_TIME_MASK and uses round-robin only, then the counter clears.
- Without the macro: pure strict priority; the counter logic is absent.

Test Plan:
- TX basic: after reset, frame of 3 words with DEST=2, LAST on word 3 -> M_WVALID=0000100b for 3 accepts, each 1 cycle after input, WREADY held 1.
- TX drop: DEST=9 with PORTS=7, 4-word frame -> no M_WVALID asserted, WREADY=1 throughout, DROP_CNT 0->1; the next DEST=0 frame forwards normally.
- TX backpressure: M_WREADY[2]=0 for 5 cycles mid-frame -> M_WDATA stable, WREADY=0 while the register is full, no word lost or duplicated.
- RX round-robin: ports 1, 3 and 5 each hold 2-word frames, mask 0 -> output order 1,1,3,3,5,5, one idle cycle between frames.
- RX real-time: mask=0000100b, ports 0 and 2 valid -> port 2 frame first, then port 0; with NETBUS_MUX_RR_STARVE_EN, port 2 flooding 9 frames -> port 0 granted after the 8th.
- Async reset asserted mid-frame on both paths -> RVALID=0, M_WVALID=0 immediately; after release WREADY=1 and DROP_CNT=0.
